// File: rtl/alu_loop_driver_pkg.sv
// Shared ALU types: operation codes, operand bundle, loop-driver FSM states and response record.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_loop_driver_pkg;

   localparam int unsigned ALU_WORD_WIDTH = 32;
   localparam int unsigned ALU_CYC_WIDTH  = 8;

   // Operation selector understood by the nibble-serial ALU loop
   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_COMP = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5
   } AluCtrl;

   // Operand bundle held stable towards the loop for a whole operation
   typedef struct packed {
      AluCtrl                    ctrl;
      logic [ALU_WORD_WIDTH-1:0] word1;
      logic [ALU_WORD_WIDTH-1:0] word2;
      logic [ALU_WORD_WIDTH-1:0] preinit;
      logic                      check_0xf;
      logic                      signed_neg;
      logic                      preinit_only;
   } aluParams;

   // Loop-driver sequencing states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_RUN     = 3'd2,
      ST_PRELOAD = 3'd3,
      ST_RESP    = 3'd4
   } alu_loop_state_e;

   // Captured response, held until the consumer accepts it
   typedef struct packed {
      logic [ALU_WORD_WIDTH-1:0] result;
      logic                      carry;
      logic [ALU_CYC_WIDTH-1:0]  cycles;
      logic                      error;
   } alu_loop_rsp_t;

endpackage

// File: rtl/alu_loop_cycle_counter.sv
// RUN-cycle counter: clears on clr_i, counts on inc_i, saturates at 255; optional watchdog flag.
// Latency: count visible the cycle after the increment; timeout_o is combinational on the count.
// Backpressure: none; counting is purely driven by the owning FSM.
// Watchdog compare exists only when ALU_LOOP_DRIVER_TIMEOUT_EN is defined.
module alu_loop_cycle_counter
   import alu_loop_driver_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     inc_i,
   output logic [ALU_CYC_WIDTH-1:0] cnt_o,
   output logic                     timeout_o
);

   logic [ALU_CYC_WIDTH-1:0] cnt_q;
   logic [ALU_CYC_WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise increment and stick at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

`ifdef ALU_LOOP_DRIVER_TIMEOUT_EN
   // Count already holds the completed RUN cycles, so the limit is reached after exactly that many busy cycles
   assign timeout_o = ({{(32-ALU_CYC_WIDTH){1'b0}}, cnt_q} >= TIMEOUT_CYCLES);
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/alu_loop_driver.sv
// Request/response front end for the nibble-serial ALU loop: IDLE->ARM->RUN->RESP or IDLE->PRELOAD->RESP.
// Latency: response 2 edges after handshake for preload, 3+k for a loop (k = busy RUN cycles).
// Backpressure: req_ready only in IDLE; RESP holds all rsp_* stable until rsp_ready. Watchdog: ALU_LOOP_DRIVER_TIMEOUT_EN.
module alu_loop_driver
   import alu_loop_driver_pkg::*;
#(
   parameter int unsigned  ALU_BITS_WIDTH = 4,
   parameter int unsigned  TIMEOUT_CYCLES = 64,
   localparam int unsigned NW             = $clog2(32 / ALU_BITS_WIDTH)
)(
   input  logic          clk,
   input  logic          rst_n,
   // request
   input  logic          req_valid,
   output logic          req_ready,
   input  AluCtrl        req_ctrl,
   input  logic [31:0]   req_word1,
   input  logic [31:0]   req_word2,
   input  logic [NW-1:0] req_nibbles,
   input  logic          req_check_0xf,
   input  logic          req_signed_neg,
   input  logic [31:0]   req_preinit,
   input  logic          req_preinit_only,
   // response
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_result,
   output logic          rsp_carry,
   output logic [7:0]    rsp_cycles,
   output logic          rsp_error,
   // loop side
   output logic          loop_perm_to_count,
   output logic [NW-1:0] loop_nibbles_number,
   output AluCtrl        ctrl,
   output logic [31:0]   word1,
   output logic [31:0]   word2,
   output logic          check_if_result_0xF,
   output logic          word2_is_signed_and_negative,
   output logic [31:0]   preinit_result,
   output logic          enable_preinit_only,
   input  logic          busy,
   input  logic [31:0]   result,
   input  logic          carry_in_out
);

   alu_loop_state_e          state_q;
   aluParams                 ops_q;
   logic [NW-1:0]            nib_q;
   logic                     req_ready_q;
   logic                     perm_q;
   logic                     preinit_en_q;
   logic                     rsp_valid_q;
   alu_loop_rsp_t            rsp_q;
   logic [ALU_CYC_WIDTH-1:0] run_cnt;
   logic                     run_timeout;
   logic                     cnt_clr;
   logic                     cnt_inc;

   assign cnt_clr = (state_q == ST_ARM) || (state_q == ST_PRELOAD);
   assign cnt_inc = (state_q == ST_RUN);

   alu_loop_cycle_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_cycle_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (cnt_clr),
      .inc_i     (cnt_inc),
      .cnt_o     (run_cnt),
      .timeout_o (run_timeout)
   );

   // Sequencer with registered handshake and loop-control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ops_q        <= '0;
         nib_q        <= '0;
         req_ready_q  <= 1'b1;
         perm_q       <= 1'b0;
         preinit_en_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_q        <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  ops_q       <= '{ctrl: req_ctrl, word1: req_word1, word2: req_word2,
                                   preinit: req_preinit, check_0xf: req_check_0xf,
                                   signed_neg: req_signed_neg, preinit_only: req_preinit_only};
                  nib_q       <= req_nibbles;
                  req_ready_q <= 1'b0;
                  if (req_preinit_only) begin
                     state_q      <= ST_PRELOAD;
                     preinit_en_q <= 1'b1;
                  end else begin
                     state_q <= ST_ARM;
                  end
               end
            end
            ST_ARM: begin
               // perm low for this one cycle lets the loop load its counter and carry
               perm_q  <= 1'b1;
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (!busy || run_timeout) begin
                  rsp_q       <= '{result: result, carry: carry_in_out, cycles: run_cnt,
                                   error: busy && run_timeout};
                  perm_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_PRELOAD: begin
               rsp_q        <= '{result: ops_q.preinit, carry: 1'b0, cycles: '0, error: 1'b0};
               preinit_en_q <= 1'b0;
               rsp_valid_q  <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               perm_q      <= 1'b0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready                    = req_ready_q;
   assign rsp_valid                    = rsp_valid_q;
   assign rsp_result                   = rsp_q.result;
   assign rsp_carry                    = rsp_q.carry;
   assign rsp_cycles                   = rsp_q.cycles;
   assign rsp_error                    = rsp_q.error;
   assign loop_perm_to_count           = perm_q;
   assign enable_preinit_only          = preinit_en_q;
   assign loop_nibbles_number          = nib_q;
   assign ctrl                         = ops_q.ctrl;
   assign word1                        = ops_q.word1;
   assign word2                        = ops_q.word2;
   assign check_if_result_0xF          = ops_q.check_0xf;
   assign word2_is_signed_and_negative = ops_q.signed_neg;
   assign preinit_result               = ops_q.preinit;

endmodule

// File: tb/tb_alu_loop_driver.sv
// Directed bench for alu_loop_driver with a behavioural ALU loop and a response scoreboard.
// Latency: measured in edges from the handshake edge (inclusive) to rsp_valid.
// Backpressure: rsp_ready held low in one step; watchdog step depends on ALU_LOOP_DRIVER_TIMEOUT_EN.
module tb_alu_loop_driver;
   import alu_loop_driver_pkg::*;

   typedef struct {
      logic [31:0] result;
      logic        carry;
      logic [7:0]  cycles;
      logic        error;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   AluCtrl      req_ctrl = ALU_ADD;
   logic [31:0] req_word1 = '0;
   logic [31:0] req_word2 = '0;
   logic [2:0]  req_nibbles = '0;
   logic        req_check_0xf = 1'b0;
   logic        req_signed_neg = 1'b0;
   logic [31:0] req_preinit = '0;
   logic        req_preinit_only = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_result;
   logic        rsp_carry;
   logic [7:0]  rsp_cycles;
   logic        rsp_error;
   logic        loop_perm_to_count;
   logic [2:0]  loop_nibbles_number;
   AluCtrl      ctrl;
   logic [31:0] word1;
   logic [31:0] word2;
   logic        check_if_result_0xF;
   logic        word2_is_signed_and_negative;
   logic [31:0] preinit_result;
   logic        enable_preinit_only;
   logic        busy;
   logic [31:0] result;
   logic        carry_in_out;

   int          checks = 0;
   int          failures = 0;
   exp_t        sb[$];
   int unsigned rem = 0;
   int unsigned hold_n = 0;
   logic        perm_seen = 1'b0;
   logic [31:0] calc_r;
   logic        calc_c;

   alu_loop_driver #(
      .ALU_BITS_WIDTH (4),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .req_valid (req_valid), .req_ready (req_ready), .req_ctrl (req_ctrl),
      .req_word1 (req_word1), .req_word2 (req_word2), .req_nibbles (req_nibbles),
      .req_check_0xf (req_check_0xf), .req_signed_neg (req_signed_neg),
      .req_preinit (req_preinit), .req_preinit_only (req_preinit_only),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_result (rsp_result),
      .rsp_carry (rsp_carry), .rsp_cycles (rsp_cycles), .rsp_error (rsp_error),
      .loop_perm_to_count (loop_perm_to_count), .loop_nibbles_number (loop_nibbles_number),
      .ctrl (ctrl), .word1 (word1), .word2 (word2),
      .check_if_result_0xF (check_if_result_0xF),
      .word2_is_signed_and_negative (word2_is_signed_and_negative),
      .preinit_result (preinit_result), .enable_preinit_only (enable_preinit_only),
      .busy (busy), .result (result), .carry_in_out (carry_in_out)
   );

   always #5 clk = ~clk;

   // Loop model: loads its slice count while perm is low, then stays busy that many permitted cycles
   always @(posedge clk) begin
      if (!loop_perm_to_count) rem <= (hold_n != 0) ? hold_n : 32'(loop_nibbles_number) + 1;
      else if (rem != 0)       rem <= rem - 1;
   end
   assign busy = loop_perm_to_count && (rem != 0);

   // Loop model datapath: intermediate junk while busy, final value once done
   always_comb begin
      calc_r = '0;
      calc_c = 1'b0;
      case (ctrl)
         ALU_ADD:  {calc_c, calc_r} = {1'b0, word1} + {1'b0, word2};
         ALU_COMP: calc_c = (word1 > word2);
         default:  calc_r = word1 ^ word2;
      endcase
   end
   assign result       = busy ? 32'hDEAD_BEEF : calc_r;
   assign carry_in_out = busy ? 1'b0 : calc_c;

   always @(posedge loop_perm_to_count) perm_seen = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input string tag, input AluCtrl c, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [2:0] nib, input logic pre_only,
                          input logic [31:0] pre, input int unsigned hold, input int bp,
                          input exp_t e);
      exp_t x;
      int   lat;
      sb.push_back(e);
      hold_n    = hold;
      rsp_ready = (bp == 0);
      perm_seen = 1'b0;
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_ctrl = c; req_word1 = w1; req_word2 = w2; req_nibbles = nib;
      req_preinit_only = pre_only; req_preinit = pre; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
      x = sb.pop_front();
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".result"},    rsp_result,     x.result);
      check({tag, ".carry"},     32'(rsp_carry), 32'(x.carry));
      check({tag, ".cycles"},    32'(rsp_cycles), 32'(x.cycles));
      check({tag, ".error"},     32'(rsp_error), 32'(x.error));
      check({tag, ".latency"},   32'(lat),       32'(x.lat));
      check({tag, ".perm_seen"}, 32'(perm_seen), pre_only ? 32'd0 : 32'd1);
      for (int i = 0; i < bp; i++) begin
         req_valid = 1'b1; req_word1 = ~w1; req_preinit_only = 1'b0;
         @(posedge clk); #1;
         check({tag, ".bp_valid"},     32'(rsp_valid), 32'd1);
         check({tag, ".bp_result"},    rsp_result,     x.result);
         check({tag, ".bp_cycles"},    32'(rsp_cycles), 32'(x.cycles));
         check({tag, ".bp_req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".drain_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, ".idle_ready"},  32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check({tag, ".no_queued"},   32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #1;
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.perm",      32'(loop_perm_to_count), 32'd0);
      check("rst.preinit",   32'(enable_preinit_only), 32'd0);
      check("rst.result",    rsp_result, 32'd0);
      check("rst.cycles",    32'(rsp_cycles), 32'd0);
      check("rst.error",     32'(rsp_error), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst.req_ready", 32'(req_ready), 32'd1);

      run_txn("add", ALU_ADD, 32'h00ff_0004, 32'd4, 3'd0, 1'b0, 32'h00ff_0004, 0, 0,
              '{result: 32'h00ff_0008, carry: 1'b0, cycles: 8'd1, error: 1'b0, lat: 4});
      run_txn("comp", ALU_COMP, 32'h1234_1234, 32'h1234_1233, 3'd7, 1'b0, 32'd0, 0, 0,
              '{result: 32'h0, carry: 1'b1, cycles: 8'd8, error: 1'b0, lat: 11});
      run_txn("preload", ALU_ADD, 32'h1111_1111, 32'h2, 3'd3, 1'b1, 32'hA5A5_0000, 0, 0,
              '{result: 32'hA5A5_0000, carry: 1'b0, cycles: 8'd0, error: 1'b0, lat: 2});
      run_txn("backpr", ALU_XOR, 32'hF0F0_0F0F, 32'h0FF0_0FF0, 3'd2, 1'b0, 32'd0, 0, 5,
              '{result: 32'hFF00_00FF, carry: 1'b0, cycles: 8'd3, error: 1'b0, lat: 6});
`ifdef ALU_LOOP_DRIVER_TIMEOUT_EN
      run_txn("timeout", ALU_ADD, 32'h5, 32'h6, 3'd1, 1'b0, 32'd0, 10, 0,
              '{result: 32'hDEAD_BEEF, carry: 1'b0, cycles: 8'd4, error: 1'b1, lat: 7});
`else
      run_txn("long", ALU_ADD, 32'h5, 32'h6, 3'd1, 1'b0, 32'd0, 10, 0,
              '{result: 32'hB, carry: 1'b0, cycles: 8'd10, error: 1'b0, lat: 13});
      run_txn("saturate", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 3'd1, 1'b0, 32'd0, 300, 0,
              '{result: 32'h0, carry: 1'b1, cycles: 8'd255, error: 1'b0, lat: 303});
`endif

      // Asynchronous reset in the middle of a long RUN
      hold_n = 50;
      req_ctrl = ALU_ADD; req_word1 = 32'h77; req_word2 = 32'h1; req_nibbles = 3'd5;
      req_preinit_only = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("midrun.perm_before", 32'(loop_perm_to_count), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrun.perm",      32'(loop_perm_to_count), 32'd0);
      check("midrun.rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrun.word1",     word1, 32'd0);
      check("midrun.nibbles",   32'(loop_nibbles_number), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrun.req_ready", 32'(req_ready), 32'd1);
      check("midrun.no_rsp",    32'(rsp_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
